// File: rtl/gray_bin_sync.sv
// rtl/gray_bin_sync.sv - Gray-code pointer receiver: synchroniser, decode, step classifier
//
// Brings a Gray-coded count from a foreign clock domain into clk, converts
// it to binary and reports each observed change as an up step, down step or
// illegal multi-bit jump.
//
// Ports:
//   clk        local clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   gray_in    Gray-coded count, asynchronous to clk
//   err_clr    synchronous clear of err_sticky
//   bin_out    registered binary value of the synchronised Gray count
//   changed    one-cycle pulse when bin_out takes a new value
//   dir_up     qualifies changed: 1 = +1 step, 0 = -1 step or error
//   step_err   one-cycle pulse when more than one Gray bit changed
//   err_sticky set by step_err, held until err_clr
module gray_bin_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             changed,
    output logic             dir_up,
    output logic             step_err,
    output logic             err_sticky
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Plain flop chain: nothing may sit between these stages.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gray_s;

    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic             changed_q;
    logic             dir_up_q;
    logic             step_err_q;
    logic             err_sticky_q;

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] diff;
    logic             any_change;
    logic             multi_change;
    logic             is_up;

    assign gray_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Binary bit i is the XOR of Gray bits i..MSB.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(gray_s >> i);
        end
    end

    // diff & (diff - 1) clears the lowest set bit; anything left means two or
    // more bits flipped in one sample.
    always_comb begin
        diff         = gray_s ^ gray_q;
        any_change   = |diff;
        multi_change = |(diff & (diff - ONE));
        is_up        = (bin_d == (bin_q + ONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q       <= '0;
            bin_q        <= '0;
            changed_q    <= 1'b0;
            dir_up_q     <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            gray_q     <= gray_s;
            changed_q  <= any_change;
            dir_up_q   <= any_change & ~multi_change & is_up;
            step_err_q <= multi_change;
            // Even an illegal jump is tracked so bin_out follows the producer.
            if (any_change) begin
                bin_q <= bin_d;
            end
            // A new error takes precedence over a simultaneous clear.
            if (multi_change) begin
                err_sticky_q <= 1'b1;
            end else if (err_clr) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign bin_out    = bin_q;
    assign changed    = changed_q;
    assign dir_up     = dir_up_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_gray_bin_sync.sv
// tb/tb_gray_bin_sync.sv - self-checking bench for gray_bin_sync
module tb_gray_bin_sync;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] bin_out;
    logic       changed;
    logic       dir_up;
    logic       step_err;
    logic       err_sticky;

    int errors = 0;
    int checks = 0;

    gray_bin_sync #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .bin_out    (bin_out),
        .changed    (changed),
        .dir_up     (dir_up),
        .step_err   (step_err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic       clr;
        logic [3:0] bin;
        logic       chg;
        logic       dir;
        logic       serr;
        logic       sticky;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] g, input logic clr, input logic [3:0] bin,
                       input logic chg, input logic dir, input logic serr, input logic sticky);
        vec_t v;
        v.g = g; v.clr = clr; v.bin = bin; v.chg = chg; v.dir = dir; v.serr = serr; v.sticky = sticky;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] bin, input logic chg,
                             input logic dir, input logic serr, input logic sticky);
        check({tag, ".bin_out"},    int'(bin_out),    int'(bin));
        check({tag, ".changed"},    int'(changed),    int'(chg));
        check({tag, ".dir_up"},     int'(dir_up),     int'(dir));
        check({tag, ".step_err"},   int'(step_err),   int'(serr));
        check({tag, ".err_sticky"}, int'(err_sticky), int'(sticky));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;

        // Expected outputs after edge i reflect gray of vector i-2 against i-3
        // (two synchroniser stages plus the compare register).
        //   g       clr   bin    chg dir err stk
        add(4'b0001, 0, 4'd0,  0, 0, 0, 0);  // 0  up sequence, hold 4
        add(4'b0001, 0, 4'd0,  0, 0, 0, 0);
        add(4'b0001, 0, 4'd1,  1, 1, 0, 0);
        add(4'b0001, 0, 4'd1,  0, 0, 0, 0);
        add(4'b0011, 0, 4'd1,  0, 0, 0, 0);  // 4
        add(4'b0011, 0, 4'd1,  0, 0, 0, 0);
        add(4'b0011, 0, 4'd2,  1, 1, 0, 0);
        add(4'b0011, 0, 4'd2,  0, 0, 0, 0);
        add(4'b0010, 0, 4'd2,  0, 0, 0, 0);  // 8
        add(4'b0010, 0, 4'd2,  0, 0, 0, 0);
        add(4'b0010, 0, 4'd3,  1, 1, 0, 0);
        add(4'b0010, 0, 4'd3,  0, 0, 0, 0);
        add(4'b0110, 0, 4'd3,  0, 0, 0, 0);  // 12
        add(4'b0110, 0, 4'd3,  0, 0, 0, 0);
        add(4'b0110, 0, 4'd4,  1, 1, 0, 0);
        add(4'b0110, 0, 4'd4,  0, 0, 0, 0);
        add(4'b0010, 0, 4'd4,  0, 0, 0, 0);  // 16 back-to-back down steps
        add(4'b0011, 0, 4'd4,  0, 0, 0, 0);
        add(4'b0001, 0, 4'd3,  1, 0, 0, 0);
        add(4'b0000, 0, 4'd2,  1, 0, 0, 0);
        add(4'b0000, 0, 4'd1,  1, 0, 0, 0);  // 20
        add(4'b0000, 0, 4'd0,  1, 0, 0, 0);
        add(4'b1000, 0, 4'd0,  0, 0, 0, 0);  // 22 down wrap 0 -> 15
        add(4'b1000, 0, 4'd0,  0, 0, 0, 0);
        add(4'b1000, 0, 4'd15, 1, 0, 0, 0);
        add(4'b0000, 0, 4'd15, 0, 0, 0, 0);  // 25 up wrap 15 -> 0
        add(4'b0000, 0, 4'd15, 0, 0, 0, 0);
        add(4'b0000, 0, 4'd0,  1, 1, 0, 0);
        add(4'b0001, 0, 4'd0,  0, 0, 0, 0);  // 28 back-to-back up steps
        add(4'b0011, 0, 4'd0,  0, 0, 0, 0);
        add(4'b0010, 0, 4'd1,  1, 1, 0, 0);
        add(4'b0010, 0, 4'd2,  1, 1, 0, 0);
        add(4'b0010, 0, 4'd3,  1, 1, 0, 0);
        add(4'b0010, 0, 4'd3,  0, 0, 0, 0);
        add(4'b0000, 0, 4'd3,  0, 0, 0, 0);  // 34 single-bit but non-adjacent (3 -> 0)
        add(4'b0000, 0, 4'd3,  0, 0, 0, 0);
        add(4'b0000, 0, 4'd0,  1, 0, 0, 0);
        add(4'b0011, 0, 4'd0,  0, 0, 0, 0);  // 37 illegal jump 0 -> 0011
        add(4'b0011, 0, 4'd0,  0, 0, 0, 0);
        add(4'b0011, 0, 4'd2,  1, 0, 1, 1);
        add(4'b0011, 1, 4'd2,  0, 0, 0, 0);  // 40 clear with no new error
        add(4'b0000, 0, 4'd2,  0, 0, 0, 0);
        add(4'b0000, 0, 4'd2,  0, 0, 0, 0);
        add(4'b0011, 0, 4'd0,  1, 0, 1, 1);  // 43 jump back 0011 -> 0000
        add(4'b0011, 0, 4'd0,  0, 0, 0, 1);
        add(4'b0011, 1, 4'd2,  1, 0, 1, 1);  // 45 clear coincides with error: set wins
        add(4'b0011, 0, 4'd2,  0, 0, 0, 1);
        add(4'b0011, 1, 4'd2,  0, 0, 0, 0);
        add(4'b0011, 0, 4'd2,  0, 0, 0, 0);

        // Reset held with a non-zero input: everything stays 0.
        rst_n   = 1'b0;
        gray_in = 4'b0101;
        err_clr = 1'b0;
        repeat (3) tick();
        check_all("reset_hold", 4'd0, 0, 0, 0, 0);

        // Release: 0101 against gray_q = 0 is a two-bit jump, seen on edge 3.
        rst_n = 1'b1;
        tick();
        check("post_reset_e1.changed", int'(changed), 0);
        tick();
        check("post_reset_e2.changed", int'(changed), 0);
        tick();
        check_all("post_reset_e3", 4'd6, 1, 0, 1, 1);
        tick();
        check_all("post_reset_e4", 4'd6, 0, 0, 0, 1);

        // Start the table from a clean all-zero state.
        rst_n   = 1'b0;
        gray_in = 4'b0000;
        #2;
        rst_n = 1'b1;
        repeat (4) tick();
        check_all("clean_start", 4'd0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            gray_in = vecs[i].g;
            err_clr = vecs[i].clr;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].chg, vecs[i].dir,
                      vecs[i].serr, vecs[i].sticky);
        end
        err_clr = 1'b0;

        // Async reset while an error pulse is on the outputs: 0011 -> 0101 is illegal.
        gray_in = 4'b0101;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (changed) seen = 1'b1;
        end
        check("midpulse_wait.changed", int'(seen), 1);
        check_all("midpulse_before", 4'd6, 1, 0, 1, 1);
        rst_n = 1'b0;
        #1;
        check_all("midpulse_async", 4'd0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
